fx2_fifo_responder: RTL and testbench

FX2_FIFO_RESPONDER -- requirements
Module: fx2_fifo_responder

---
 rtl/fx2_fifo_responder.sv | 120 ++++++++++++
 tb/tb_fx2_fifo_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fx2_fifo_responder.sv
// FX2 slave-FIFO responder: EP2 (host->FPGA) show-ahead FIFO and EP6 (FPGA->host)
// packet FIFO with commit pointer, both driven by the FPGA-side slave-FIFO master.
module fx2_fifo_responder #(
    parameter int DEPTH    = 16,
    parameter int PKT_SIZE = 8
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [1:0] fifoadr,
    input  logic       slrd_n,
    input  logic       slwr_n,
    input  logic       sloe_n,
    input  logic       pktend_n,
    input  logic [7:0] fd_in,
    output logic [7:0] fd_out,
    output logic       fd_oe,
    output logic       ep2_empty_n,
    output logic       ep6_full_n,
    input  logic       h_wr_valid,
    input  logic [7:0] h_wr_data,
    output logic       h_wr_ready,
    output logic       h_rd_valid,
    output logic [7:0] h_rd_data,
    output logic       h_rd_last,
    input  logic       h_rd_ready,
    output logic       ovf_err,
    output logic       udf_err
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;
    localparam ptr_t ONE     = ptr_t'(1);
    localparam ptr_t PKT_LIM = ptr_t'(PKT_SIZE);

    logic [7:0] ep2_mem [DEPTH];
    logic [8:0] ep6_mem [DEPTH];

    ptr_t wp2, rp2, wp6, cp6, rp6, ucnt;
    ptr_t wp2_nxt, rp2_nxt, wp6_nxt, cp6_nxt, rp6_nxt, ucnt_nxt, wp6_prev;
    logic rd2, push2, pop2, wr6, pe6, push6, pop6, last_new, tag_old;

    function automatic logic is_full(input ptr_t w, input ptr_t r);
        return (w[AW] != r[AW]) && (w[AW-1:0] == r[AW-1:0]);
    endfunction

    always_comb begin
        rd2      = !slrd_n && (fifoadr == 2'b00);
        push2    = h_wr_valid && h_wr_ready;
        pop2     = rd2 && ep2_empty_n;
        wp2_nxt  = wp2 + ptr_t'(push2);
        rp2_nxt  = rp2 + ptr_t'(pop2);

        wr6      = !slwr_n && (fifoadr == 2'b10);
        pe6      = !pktend_n && (fifoadr == 2'b10);
        push6    = wr6 && ep6_full_n;
        pop6     = h_rd_valid && h_rd_ready;
        last_new = ((ucnt + ONE) == PKT_LIM) || pe6;
        wp6_prev = wp6 - ONE;
        wp6_nxt  = wp6 + ptr_t'(push6);
        rp6_nxt  = rp6 + ptr_t'(pop6);
        cp6_nxt  = cp6;
        ucnt_nxt = ucnt;
        tag_old  = 1'b0;
        if (push6) begin
            if (last_new) begin
                cp6_nxt  = wp6 + ONE;
                ucnt_nxt = '0;
            end else begin
                ucnt_nxt = ucnt + ONE;
            end
        end else if (pe6 && (ucnt != '0)) begin
            // PKTEND without data closes the open packet by tagging its newest byte
            tag_old  = 1'b1;
            cp6_nxt  = wp6;
            ucnt_nxt = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wp2         <= '0;
            rp2         <= '0;
            wp6         <= '0;
            cp6         <= '0;
            rp6         <= '0;
            ucnt        <= '0;
            ep2_empty_n <= 1'b0;
            ep6_full_n  <= 1'b1;
            h_wr_ready  <= 1'b1;
            h_rd_valid  <= 1'b0;
            ovf_err     <= 1'b0;
            udf_err     <= 1'b0;
        end else begin
            wp2         <= wp2_nxt;
            rp2         <= rp2_nxt;
            wp6         <= wp6_nxt;
            cp6         <= cp6_nxt;
            rp6         <= rp6_nxt;
            ucnt        <= ucnt_nxt;
            ep2_empty_n <= (wp2_nxt != rp2_nxt);
            h_wr_ready  <= !is_full(wp2_nxt, rp2_nxt);
            ep6_full_n  <= !is_full(wp6_nxt, rp6_nxt);
            h_rd_valid  <= (cp6_nxt != rp6_nxt);
            if (rd2 && !ep2_empty_n) udf_err <= 1'b1;
            if (wr6 && !ep6_full_n)  ovf_err <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            if (push2) ep2_mem[wp2[AW-1:0]] <= h_wr_data;
            if (push6) ep6_mem[wp6[AW-1:0]] <= {last_new, fd_in};
            else if (tag_old) ep6_mem[wp6_prev[AW-1:0]][8] <= 1'b1;
        end
    end

    assign fd_out    = ep2_empty_n ? ep2_mem[rp2[AW-1:0]] : '0;
    assign fd_oe     = !sloe_n && (fifoadr == 2'b00);
    assign h_rd_data = ep6_mem[rp6[AW-1:0]][7:0];
    assign h_rd_last = h_rd_valid && ep6_mem[rp6[AW-1:0]][8];
endmodule

// File: tb/tb_fx2_fifo_responder.sv
// Self-checking bench for fx2_fifo_responder: EP2 vector table, EP6 packet scoreboard,
// overflow/underflow, pktend and mid-packet reset sequences.
module tb_fx2_fifo_responder;
    logic       clk = 1'b0;
    logic       sys_rst;
    logic [1:0] fifoadr;
    logic       slrd_n, slwr_n, sloe_n, pktend_n;
    logic [7:0] fd_in, fd_out;
    logic       fd_oe, ep2_empty_n, ep6_full_n;
    logic       h_wr_valid, h_wr_ready;
    logic [7:0] h_wr_data, h_rd_data;
    logic       h_rd_valid, h_rd_last, h_rd_ready;
    logic       ovf_err, udf_err;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb2[$];
    logic [8:0] sb6[$];

    always #5 clk = ~clk;

    fx2_fifo_responder #(.DEPTH(16), .PKT_SIZE(8)) dut (
        .sys_clk(clk), .sys_rst(sys_rst), .fifoadr(fifoadr),
        .slrd_n(slrd_n), .slwr_n(slwr_n), .sloe_n(sloe_n), .pktend_n(pktend_n),
        .fd_in(fd_in), .fd_out(fd_out), .fd_oe(fd_oe),
        .ep2_empty_n(ep2_empty_n), .ep6_full_n(ep6_full_n),
        .h_wr_valid(h_wr_valid), .h_wr_data(h_wr_data), .h_wr_ready(h_wr_ready),
        .h_rd_valid(h_rd_valid), .h_rd_data(h_rd_data), .h_rd_last(h_rd_last),
        .h_rd_ready(h_rd_ready), .ovf_err(ovf_err), .udf_err(udf_err)
    );

    typedef struct {
        logic       hv;
        logic [7:0] hd;
        logic       rd_n;
        logic [1:0] adr;
        logic       oe_n;
        logic       e_empty_n;
        logic       chk_fd;
        logic [7:0] e_fd;
        logic       e_oe;
        logic       e_udf;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic w6(input logic [1:0] a, input logic [7:0] d, input logic pe);
        fifoadr = a; fd_in = d; slwr_n = 1'b0; pktend_n = !pe;
        tick();
        slwr_n = 1'b1; pktend_n = 1'b1; fifoadr = 2'b00;
    endtask

    task automatic pe_only();
        fifoadr = 2'b10; pktend_n = 1'b0;
        tick();
        pktend_n = 1'b1; fifoadr = 2'b00;
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_empty_n"}, ep2_empty_n, 0);
        chk({tag, "_full_n"},  ep6_full_n,  1);
        chk({tag, "_wr_ready"}, h_wr_ready, 1);
        chk({tag, "_rd_valid"}, h_rd_valid, 0);
        chk({tag, "_rd_last"},  h_rd_last,  0);
        chk({tag, "_fd_out"},   fd_out,     0);
        chk({tag, "_ovf"},      ovf_err,    0);
        chk({tag, "_udf"},      udf_err,    0);
    endtask

    task automatic drain6(output int n, output int nl);
        logic [8:0] e;
        n = 0; nl = 0; h_rd_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (!h_rd_valid) break;
            if (sb6.size() == 0) begin
                total++; bad++;
                $display("FAIL ep6_extra: got %0h want none", {h_rd_last, h_rd_data});
                break;
            end
            e = sb6.pop_front();
            chk("ep6_byte", {h_rd_last, h_rd_data}, e);
            n++;
            if (h_rd_last) nl++;
            tick();
        end
        h_rd_ready = 1'b0;
        chk("ep6_sb_left", sb6.size(), 0);
    endtask

    initial begin
        int n, nl;
        // hv  hd    rd_n adr    oe_n | empty_n chk_fd fd    oe  udf
        tbl[0]  = '{1'b1, 8'h11, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 8'h22, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 8'h33, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};

        sys_rst = 1'b1; fifoadr = 2'b00; slrd_n = 1'b1; slwr_n = 1'b1; sloe_n = 1'b1;
        pktend_n = 1'b1; fd_in = '0; h_wr_valid = 1'b0; h_wr_data = '0; h_rd_ready = 1'b0;
        tick(); tick();
        rst_chk("rst");
        sys_rst = 1'b0;

        // EP2 show-ahead, pop order, underflow, fd_oe decode
        foreach (tbl[i]) begin
            h_wr_valid = tbl[i].hv; h_wr_data = tbl[i].hd; slrd_n = tbl[i].rd_n;
            fifoadr = tbl[i].adr; sloe_n = tbl[i].oe_n;
            tick();
            chk($sformatf("v%0d_empty_n", i), ep2_empty_n, tbl[i].e_empty_n);
            if (tbl[i].chk_fd) chk($sformatf("v%0d_fd_out", i), fd_out, tbl[i].e_fd);
            chk($sformatf("v%0d_fd_oe", i), fd_oe, tbl[i].e_oe);
            chk($sformatf("v%0d_udf", i), udf_err, tbl[i].e_udf);
        end
        h_wr_valid = 1'b0; slrd_n = 1'b1; sloe_n = 1'b1; fifoadr = 2'b00;

        // Occupancy 5, then simultaneous push + pop keeps it at 5
        for (int i = 0; i < 5; i++) begin
            h_wr_valid = 1'b1; h_wr_data = 8'hA0 + 8'(i); sb2.push_back(h_wr_data);
            tick();
        end
        h_wr_data = 8'hA5; slrd_n = 1'b0;
        chk("sim_head", fd_out, sb2.pop_front());
        sb2.push_back(8'hA5);
        tick();
        h_wr_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!ep2_empty_n) break;
            chk("ep2_drain", fd_out, sb2.pop_front());
            n++;
            tick();
        end
        slrd_n = 1'b1;
        chk("ep2_occupancy", n, 5);

        // Full 8-byte packet auto-commits on the 8th byte only
        for (int i = 0; i < 8; i++) begin
            w6(2'b10, 8'(i), 1'b0);
            sb6.push_back({i == 7, 8'(i)});
            if (i == 6) chk("pkt8_not_yet", h_rd_valid, 0);
        end
        chk("pkt8_valid", h_rd_valid, 1);
        drain6(n, nl);
        chk("pkt8_n", n, 8);
        chk("pkt8_last", nl, 1);

        // Short packet closed by lone PKTEND; second PKTEND is zero-length
        for (int i = 0; i < 3; i++) begin
            w6(2'b10, 8'h50 + 8'(i), 1'b0);
            sb6.push_back({i == 2, 8'h50 + 8'(i)});
        end
        chk("pkt3_pending", h_rd_valid, 0);
        pe_only();
        chk("pkt3_valid", h_rd_valid, 1);
        drain6(n, nl);
        chk("pkt3_n", n, 3);
        pe_only(); tick();
        chk("zlp_valid", h_rd_valid, 0);
        chk("zlp_ovf", ovf_err, 0);

        // PKTEND together with the write marks that byte last
        w6(2'b10, 8'h60, 1'b0); sb6.push_back({1'b0, 8'h60});
        w6(2'b10, 8'h61, 1'b1); sb6.push_back({1'b1, 8'h61});
        drain6(n, nl);
        chk("pkt2_n", n, 2);

        // Fill EP6 to 16 with no reader, 17th write dropped
        for (int i = 0; i < 16; i++) begin
            w6(2'b10, 8'h80 + 8'(i), 1'b0);
            sb6.push_back({(i == 7) || (i == 15), 8'h80 + 8'(i)});
            if (i == 14) chk("full_n_at15", ep6_full_n, 1);
        end
        chk("full_n_at16", ep6_full_n, 0);
        chk("ovf_before", ovf_err, 0);
        w6(2'b10, 8'hEE, 1'b0);
        chk("ovf_after", ovf_err, 1);
        drain6(n, nl);
        chk("full_drain_n", n, 16);
        chk("full_drain_pkts", nl, 2);
        chk("full_n_after", ep6_full_n, 1);

        // Reset mid-packet discards the 5 uncommitted bytes
        for (int i = 0; i < 5; i++) w6(2'b10, 8'hC0 + 8'(i), 1'b0);
        sys_rst = 1'b1; tick(); sys_rst = 1'b0;
        rst_chk("midrst");
        pe_only(); tick();
        chk("midrst_pe_valid", h_rd_valid, 0);
        w6(2'b01, 8'hD0, 1'b0);
        w6(2'b11, 8'hD1, 1'b0);
        pe_only(); tick();
        chk("bad_adr_valid", h_rd_valid, 0);
        chk("bad_adr_ovf", ovf_err, 0);
        chk("bad_adr_udf", udf_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end
endmodule
